// File: rtl/dma_write_master.sv
// AXI4 write master: drains 32-bit words from a FWFT FIFO into INCR bursts of at
// most 256 bytes that never cross a 4 KB boundary, one burst outstanding at a time.
module dma_write_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,

  input  logic                            i_start,
  input  logic [31:0]                     i_dst_addr,
  input  logic [31:0]                     i_total_len,
  output logic                            o_write_done,
  output logic                            o_write_error,

  input  logic                            i_fifo_empty,
  input  logic [31:0]                     i_fifo_data,
  output logic                            o_fifo_pop,

  output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,

  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,

  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ADDR = 4'b0010,
    DATA = 4'b0100,
    RESP = 4'b1000
  } state_t;

  state_t      state, state_next;
  logic        awvalid_q, awvalid_next;
  logic [31:0] r_addr;
  logic [31:0] r_rem;
  logic [7:0]  r_beats;
  logic [7:0]  beat_cnt;

  logic [31:0] start_rem;
  logic [31:0] to_4k;
  logic [31:0] cap;
  logic [31:0] burst_bytes;
  logic [7:0]  burst_beats;
  logic [31:0] step_bytes;
  logic [31:0] next_addr;
  logic [31:0] next_rem;
  logic        aw_hs;
  logic        b_hs;
  logic        unused_bits;

  assign start_rem = {i_total_len[31:2], 2'b00};

  // Burst length is the smallest of what is left, 256 bytes, and the room up to the next 4 KB page.
  always_comb begin
    to_4k       = 32'h0000_1000 - {20'd0, r_addr[11:0]};
    cap         = (to_4k < 32'd256) ? to_4k : 32'd256;
    burst_bytes = (r_rem < cap) ? r_rem : cap;
    burst_beats = burst_bytes[9:2];
  end

  assign step_bytes  = {22'd0, r_beats, 2'b00};
  assign next_addr   = r_addr + step_bytes;
  assign next_rem    = r_rem - step_bytes;
  assign aw_hs       = (state == ADDR) && m_axi_awready;
  assign b_hs        = (state == RESP) && m_axi_bvalid;
  assign unused_bits = ^{i_dst_addr[1:0], i_total_len[1:0], burst_bytes[31:10], burst_bytes[1:0]};

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = awvalid_q ? (burst_beats - 8'd1) : 8'd0;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = i_fifo_data;
  assign m_axi_wstrb   = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      awvalid_q <= 1'b0;
    end else begin
      state     <= state_next;
      awvalid_q <= awvalid_next;
    end
  end

  always_comb begin
    state_next   = state;
    awvalid_next = awvalid_q;
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
    m_axi_bready = 1'b0;
    o_fifo_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start && (start_rem != 32'd0)) begin
          state_next   = ADDR;
          awvalid_next = 1'b1;
        end
      end
      ADDR: begin
        if (m_axi_awready) begin
          state_next   = DATA;
          awvalid_next = 1'b0;
        end
      end
      DATA: begin
        m_axi_wvalid = !i_fifo_empty;
        m_axi_wlast  = (beat_cnt == (r_beats - 8'd1));
        o_fifo_pop   = m_axi_wvalid && m_axi_wready;
        if (o_fifo_pop && m_axi_wlast) begin
          state_next = RESP;
        end
      end
      RESP: begin
        m_axi_bready = 1'b1;
        // Raise the next AW straight out of the B handshake so no idle cycle is lost.
        if (m_axi_bvalid) begin
          if (next_rem != 32'd0) begin
            state_next   = ADDR;
            awvalid_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        awvalid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= 32'd0;
      r_rem         <= 32'd0;
      r_beats       <= 8'd0;
      beat_cnt      <= 8'd0;
      o_write_done  <= 1'b0;
      o_write_error <= 1'b0;
    end else begin
      if ((state == IDLE) && i_start) begin
        r_addr        <= {i_dst_addr[31:2], 2'b00};
        r_rem         <= start_rem;
        o_write_done  <= (start_rem == 32'd0);
        o_write_error <= 1'b0;
      end
      if (aw_hs) begin
        r_beats  <= burst_beats;
        beat_cnt <= 8'd0;
      end
      if (o_fifo_pop) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (b_hs) begin
        r_addr <= next_addr;
        r_rem  <= next_rem;
        if (m_axi_bresp != 2'b00) begin
          o_write_error <= 1'b1;
        end
        if (next_rem == 32'd0) begin
          o_write_done <= 1'b1;
        end
      end
    end
  end

endmodule
